sig_capture_writer: RTL and testbench
=====================================

SIG_CAPTURE_WRITER -- requirements
Module: sig_capture_writer

Interface
REQ-001 SHALL have parameter ECG_BASE, default 12'h801, signal-memory start address of the ECG trace.
REQ-002 SHALL have parameter EMG_BASE, default 12'h559, signal-memory start address of the EMG trace.
REQ-003 SHALL have parameter DEPTH, default 640, entries per trace (one per display column).
REQ-004 SHALL have parameter DECIM_LOG2, default 2, log2 of samples averaged per stored entry.
REQ-005 SHALL have port clock, input, 1, single system clock; all logic in this domain.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have ports ecg_sample / emg_sample, input, 12 each, unsigned ADC codes.
REQ-008 SHALL have ports ecg_valid / emg_valid, input, 1 each, one-cycle sample strobes.
REQ-009 SHALL have port freeze, input, 1, level; when high, new samples are ignored.
REQ-010 SHALL have port clear_ovr, input, 1, pulse; clears the sticky overrun flags.
REQ-011 SHALL have ports mem_we / mem_addr / mem_wdata, output, 1/12/32, registered write port to the signal memory.
REQ-012 SHALL have ports ecg_ptr / emg_ptr, output, 10 each, index of the next entry to be written (display scroll origin).
REQ-013 SHALL have ports ecg_ovr / emg_ovr, output, 1 each, sticky overrun flags.

Function
REQ-014 Per channel, an accepted valid (freeze low) SHALL add the sample to a 12+DECIM_LOG2-bit accumulator and increment a DECIM_LOG2-bit group counter.
REQ-015 On the valid that completes a group (counter wraps to 0), the channel SHALL load (accumulator + sample) >> DECIM_LOG2 (truncate) into its pending register, set pending, and clear the accumulator in the same edge.
REQ-016 When DECIM_LOG2 = 0, each accepted valid SHALL load the sample directly into pending.
REQ-017 If a group completes while that channel's pending is still set, pending data SHALL be overwritten with the new value and the channel's ovr flag set.
REQ-018 Write arbiter SHALL issue at most one write per cycle: one requester wins; if both pending, round-robin with the ECG channel winning the first tie after reset.
REQ-019 A granted write SHALL drive, on the next edge, mem_we = 1, mem_addr = BASE + ptr, mem_wdata = {20'b0, value}, clear that pending, and advance ptr.
REQ-020 Latency: pending set at edge E0 SHALL produce mem_we high from E1 to E2 when uncontended; the losing channel writes one cycle later.
REQ-021 mem_we SHALL be low in every cycle with no grant; mem_addr/mem_wdata SHALL hold their last value then.
REQ-022 ptr SHALL count 0..DEPTH-1 and wrap DEPTH-1 -> 0; address SHALL never exceed BASE+DEPTH-1.
REQ-023 freeze high SHALL ignore valids and hold accumulators and counters, while already-pending entries still drain.
REQ-024 A group completion and a grant for the same channel on the same edge SHALL leave pending set with the new value and no ovr.
REQ-025 clear_ovr SHALL clear both flags; a simultaneous overrun event SHALL take priority (flag stays set).

Reset
REQ-026 While reset = 0: mem_we = 0, mem_addr = 0, mem_wdata = 0, ptrs = 0, ovr = 0, pending = 0, accumulators and counters = 0, round-robin to ECG.
REQ-027 Reset asserted mid-group or with pending writes SHALL discard partial data; no write SHALL issue in the first cycle after release.

Structure
REQ-028 DEPTH, default bases, and the 32-bit word / 12-bit sample widths SHALL live in a shared signal-memory package also used by the display controller.
REQ-029 Per-channel accumulate/decimate/pending logic SHALL be one sub-module, sig_decimator, instantiated twice; arbiter and pointers stay in the top.

Verification
REQ-030 DECIM_LOG2 = 2, four ECG valids 100, 104, 108, 112 -> exactly one write: addr 12'h801, data 106, ecg_ptr 0 -> 1.
REQ-031 Both channels complete a group on the same edge -> ECG write in the next cycle, EMG write (addr 12'h559) in the cycle after; the next tie goes to EMG.
REQ-032 640 EMG groups with constant sample 0xFFF -> last write to 12'h7D8 data 0xFFF, emg_ptr wraps to 0, the 641st group writes 12'h559.
REQ-033 Hold arbiter busy on ECG every cycle while EMG completes two groups -> emg_ovr = 1, the single EMG write carries the second value; clear_ovr pulse -> emg_ovr = 0.
REQ-034 freeze high for 10 valids mid-group, then low -> no writes during freeze, and the group resumes from its held count and sum.
REQ-035 Assert reset with 3 of 4 samples accumulated and EMG pending -> all outputs 0 during reset; after release, the next 4 valids produce one write at the base address.

Source files
------------

// File: rtl/sig_capture_writer_pkg.sv
// ============================================================================
// Module   : sig_capture_writer_pkg
// Purpose  : Shared signal-memory layout (depth, trace bases, word/sample
//            widths) used by the capture writer and the display controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sig_capture_writer_pkg;

  localparam int SIG_DEPTH    = 640;
  localparam int SIG_SAMPLE_W = 12;
  localparam int SIG_WORD_W   = 32;
  localparam int SIG_ADDR_W   = 12;
  localparam int SIG_PTR_W    = 10;

  localparam logic [SIG_ADDR_W-1:0] SIG_ECG_BASE = 12'h801;
  localparam logic [SIG_ADDR_W-1:0] SIG_EMG_BASE = 12'h559;

  typedef enum logic [0:0] {
    CH_ECG = 1'b0,
    CH_EMG = 1'b1
  } chan_e;

  function automatic logic [SIG_WORD_W-1:0] sig_word(input logic [SIG_SAMPLE_W-1:0] s);
    return {{(SIG_WORD_W - SIG_SAMPLE_W){1'b0}}, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sig_capture_writer_if.sv
// ============================================================================
// Module   : sig_capture_writer_if
// Purpose  : Registered write port into the signal memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sig_capture_writer_if;
  import sig_capture_writer_pkg::*;

  logic                  mem_we;
  logic [SIG_ADDR_W-1:0] mem_addr;
  logic [SIG_WORD_W-1:0] mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

`default_nettype wire

// File: rtl/sig_decimator.sv
// ============================================================================
// Module   : sig_decimator
// Purpose  : One channel: average 2**DECIM_LOG2 samples into a pending entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_decimator
  import sig_capture_writer_pkg::*;
#(
  parameter int DECIM_LOG2 = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [SIG_SAMPLE_W-1:0] sample,
  input  logic                    freeze,
  input  logic                    grant,
  input  logic                    clear_ovr,
  output logic                    pend,
  output logic [SIG_SAMPLE_W-1:0] value,
  output logic                    ovr
);

  localparam int ACC_W = SIG_SAMPLE_W + DECIM_LOG2;

  logic                    accept;
  logic                    complete;
  logic [SIG_SAMPLE_W-1:0] avg;

  logic                    pend_q, pend_d;
  logic [SIG_SAMPLE_W-1:0] value_q, value_d;
  logic                    ovr_q, ovr_d;

  assign accept = valid & ~freeze;

  generate
    if (DECIM_LOG2 == 0) begin : g_direct
      assign complete = accept;
      assign avg      = sample;
    end else begin : g_average
      logic [ACC_W-1:0]      acc_q, acc_d;
      logic [ACC_W-1:0]      sum;
      logic [DECIM_LOG2-1:0] cnt_q, cnt_d;

      assign sum      = acc_q + ACC_W'(sample);
      assign complete = accept && (cnt_q == '1);
      assign avg      = SIG_SAMPLE_W'(sum >> DECIM_LOG2);

      always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (accept) begin
          cnt_d = cnt_q + DECIM_LOG2'(1);
          acc_d = complete ? '0 : sum;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // A completion landing on the grant edge refills the slot, which is not an overrun.
  always_comb begin
    pend_d  = pend_q;
    value_d = value_q;
    ovr_d   = ovr_q;
    if (grant)     pend_d = 1'b0;
    if (complete) begin
      pend_d  = 1'b1;
      value_d = avg;
    end
    if (clear_ovr) ovr_d = 1'b0;
    if (complete && pend_q && !grant) ovr_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q  <= 1'b0;
      value_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      value_q <= value_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pend  = pend_q;
  assign value = value_q;
  assign ovr   = ovr_q;

endmodule

`default_nettype wire

// File: rtl/sig_capture_writer.sv
// ============================================================================
// Module   : sig_capture_writer
// Purpose  : Decimate ECG/EMG streams and write them into circular traces.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_capture_writer
  import sig_capture_writer_pkg::*;
#(
  parameter logic [SIG_ADDR_W-1:0] ECG_BASE   = SIG_ECG_BASE,
  parameter logic [SIG_ADDR_W-1:0] EMG_BASE   = SIG_EMG_BASE,
  parameter int                    DEPTH      = SIG_DEPTH,
  parameter int                    DECIM_LOG2 = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SIG_SAMPLE_W-1:0] ecg_sample,
  input  logic                    ecg_valid,
  input  logic [SIG_SAMPLE_W-1:0] emg_sample,
  input  logic                    emg_valid,
  input  logic                    freeze,
  input  logic                    clear_ovr,
  sig_capture_writer_if.master    mem,
  output logic [SIG_PTR_W-1:0]    ecg_ptr,
  output logic [SIG_PTR_W-1:0]    emg_ptr,
  output logic                    ecg_ovr,
  output logic                    emg_ovr
);

  localparam logic [SIG_PTR_W-1:0] LAST_PTR = SIG_PTR_W'(DEPTH - 1);

  logic                    ecg_pend, emg_pend;
  logic [SIG_SAMPLE_W-1:0] ecg_val, emg_val;
  logic                    grant_ecg, grant_emg;

  chan_e                   rr_q, rr_d;
  logic                    mem_we_q, mem_we_d;
  logic [SIG_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [SIG_WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SIG_PTR_W-1:0]    ecg_ptr_q, ecg_ptr_d;
  logic [SIG_PTR_W-1:0]    emg_ptr_q, emg_ptr_d;

  function automatic logic [SIG_PTR_W-1:0] ptr_inc(input logic [SIG_PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + SIG_PTR_W'(1);
  endfunction

  sig_decimator #(.DECIM_LOG2(DECIM_LOG2)) u_ecg (
    .clock(clock), .reset(reset), .valid(ecg_valid), .sample(ecg_sample),
    .freeze(freeze), .grant(grant_ecg), .clear_ovr(clear_ovr),
    .pend(ecg_pend), .value(ecg_val), .ovr(ecg_ovr)
  );

  sig_decimator #(.DECIM_LOG2(DECIM_LOG2)) u_emg (
    .clock(clock), .reset(reset), .valid(emg_valid), .sample(emg_sample),
    .freeze(freeze), .grant(grant_emg), .clear_ovr(clear_ovr),
    .pend(emg_pend), .value(emg_val), .ovr(emg_ovr)
  );

  // Priority only rotates on a tie, so a lone requester never steals the next tie.
  always_comb begin
    grant_ecg = 1'b0;
    grant_emg = 1'b0;
    rr_d      = rr_q;
    if (ecg_pend && emg_pend) begin
      if (rr_q == CH_ECG) begin
        grant_ecg = 1'b1;
        rr_d      = CH_EMG;
      end else begin
        grant_emg = 1'b1;
        rr_d      = CH_ECG;
      end
    end else if (ecg_pend) begin
      grant_ecg = 1'b1;
    end else if (emg_pend) begin
      grant_emg = 1'b1;
    end
  end

  always_comb begin
    mem_we_d    = grant_ecg | grant_emg;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ecg_ptr_d   = ecg_ptr_q;
    emg_ptr_d   = emg_ptr_q;
    if (grant_ecg) begin
      mem_addr_d  = ECG_BASE + {2'b00, ecg_ptr_q};
      mem_wdata_d = sig_word(ecg_val);
      ecg_ptr_d   = ptr_inc(ecg_ptr_q);
    end else if (grant_emg) begin
      mem_addr_d  = EMG_BASE + {2'b00, emg_ptr_q};
      mem_wdata_d = sig_word(emg_val);
      emg_ptr_d   = ptr_inc(emg_ptr_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q        <= CH_ECG;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ecg_ptr_q   <= '0;
      emg_ptr_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ecg_ptr_q   <= ecg_ptr_d;
      emg_ptr_q   <= emg_ptr_d;
    end
  end

  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign ecg_ptr       = ecg_ptr_q;
  assign emg_ptr       = emg_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_sig_capture_writer.sv
// ============================================================================
// Module   : tb_sig_capture_writer
// Purpose  : Self-checking bench for sig_capture_writer (averaging and direct-load builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sig_capture_writer;
  import sig_capture_writer_pkg::*;

  localparam logic [11:0] ECG_B = 12'h801;
  localparam logic [11:0] EMG_B = 12'h559;
  localparam int          DEPTH = 640;
  localparam int          GROUP = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Averaging build (DECIM_LOG2 = 2)
  logic [11:0] ecg_sample, emg_sample;
  logic        ecg_valid, emg_valid, freeze, clear_ovr;
  logic [9:0]  ecg_ptr, emg_ptr;
  logic        ecg_ovr, emg_ovr;
  sig_capture_writer_if mem_a ();

  sig_capture_writer #(.DECIM_LOG2(2)) dut_a (
    .clock(clock), .reset(reset),
    .ecg_sample(ecg_sample), .ecg_valid(ecg_valid),
    .emg_sample(emg_sample), .emg_valid(emg_valid),
    .freeze(freeze), .clear_ovr(clear_ovr), .mem(mem_a),
    .ecg_ptr(ecg_ptr), .emg_ptr(emg_ptr), .ecg_ovr(ecg_ovr), .emg_ovr(emg_ovr)
  );

  // Direct-load build (DECIM_LOG2 = 0), used to provoke overruns
  logic [11:0] b_ecg_sample, b_emg_sample;
  logic        b_ecg_valid, b_emg_valid, b_freeze, b_clear_ovr;
  logic [9:0]  b_ecg_ptr, b_emg_ptr;
  logic        b_ecg_ovr, b_emg_ovr;
  sig_capture_writer_if mem_b ();

  sig_capture_writer #(.DECIM_LOG2(0)) dut_b (
    .clock(clock), .reset(reset),
    .ecg_sample(b_ecg_sample), .ecg_valid(b_ecg_valid),
    .emg_sample(b_emg_sample), .emg_valid(b_emg_valid),
    .freeze(b_freeze), .clear_ovr(b_clear_ovr), .mem(mem_b),
    .ecg_ptr(b_ecg_ptr), .emg_ptr(b_emg_ptr), .ecg_ovr(b_ecg_ovr), .emg_ovr(b_emg_ovr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Reference model: group sums per channel and queues of expected {addr, data}
  int          m_cnt [2];
  int          m_sum [2];
  int          m_idx [2];
  logic [23:0] exp_ecg [$];
  logic [23:0] exp_emg [$];

  function automatic void model_clear();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0;
      m_sum[c] = 0;
      m_idx[c] = 0;
    end
    exp_ecg.delete();
    exp_emg.delete();
  endfunction

  function automatic void model_accept(input int ch, input logic [11:0] s);
    logic [11:0] avg;
    logic [11:0] addr;
    m_sum[ch] += int'(s);
    m_cnt[ch]++;
    if (m_cnt[ch] == GROUP) begin
      avg  = 12'(m_sum[ch] / GROUP);
      addr = (ch == 0 ? ECG_B : EMG_B) + 12'(m_idx[ch]);
      if (ch == 0) exp_ecg.push_back({addr, avg});
      else         exp_emg.push_back({addr, avg});
      m_idx[ch] = (m_idx[ch] + 1) % DEPTH;
      m_cnt[ch] = 0;
      m_sum[ch] = 0;
    end
  endfunction

  // Write monitor for the averaging build
  int          writes_a = 0;
  logic [11:0] last_addr = '0;
  logic [23:0] mon_e;

  always @(negedge clock) begin
    if (reset && mem_a.mem_we) begin
      writes_a++;
      last_addr = mem_a.mem_addr;
      if (mem_a.mem_addr >= ECG_B) begin
        if (exp_ecg.size() == 0) check_val("ecg_unexpected_write", {20'b0, mem_a.mem_addr}, 32'hFFFF_FFFF);
        else begin
          mon_e = exp_ecg.pop_front();
          check_val("ecg_write_addr", {20'b0, mem_a.mem_addr}, {20'b0, mon_e[23:12]});
          check_val("ecg_write_data", mem_a.mem_wdata, {20'b0, mon_e[11:0]});
        end
      end else begin
        if (exp_emg.size() == 0) check_val("emg_unexpected_write", {20'b0, mem_a.mem_addr}, 32'hFFFF_FFFF);
        else begin
          mon_e = exp_emg.pop_front();
          check_val("emg_write_addr", {20'b0, mem_a.mem_addr}, {20'b0, mon_e[23:12]});
          check_val("emg_write_data", mem_a.mem_wdata, {20'b0, mon_e[11:0]});
        end
      end
    end
  end

  task automatic cyc(input logic ev, input logic [11:0] es, input logic mv,
                     input logic [11:0] ms, input logic frz);
    @(negedge clock);
    ecg_valid  = ev;
    ecg_sample = es;
    emg_valid  = mv;
    emg_sample = ms;
    freeze     = frz;
    if (!frz) begin
      if (ev) model_accept(0, es);
      if (mv) model_accept(1, ms);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    ecg_valid    = 1'b0; emg_valid = 1'b0; ecg_sample = '0; emg_sample = '0;
    freeze       = 1'b0; clear_ovr = 1'b0;
    b_ecg_valid  = 1'b0; b_emg_valid = 1'b0; b_ecg_sample = '0; b_emg_sample = '0;
    b_freeze     = 1'b0; b_clear_ovr = 1'b0;
    model_clear();
    @(negedge clock); #1;
    check_val("rst_mem_we",    {31'b0, mem_a.mem_we}, 32'd0);
    check_val("rst_mem_addr",  {20'b0, mem_a.mem_addr}, 32'd0);
    check_val("rst_mem_wdata", mem_a.mem_wdata, 32'd0);
    check_val("rst_ptrs",      {12'b0, ecg_ptr, emg_ptr}, 32'd0);
    check_val("rst_ovr",       {30'b0, ecg_ovr, emg_ovr}, 32'd0);
    reset = 1'b1;
    @(negedge clock); #1;
    check_val("post_rst_no_write", {31'b0, mem_a.mem_we}, 32'd0);
  endtask

  int w0;

  initial begin
    do_reset();

    // Single ECG group: 100,104,108,112 -> 106 at the ECG base
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'(100 + 4 * i), 1'b0, 12'd0, 1'b0);
    idle(1);
    check_val("lat_no_write_yet", {31'b0, mem_a.mem_we}, 32'd0);
    check_val("lat_ptr_before",   {22'b0, ecg_ptr}, 32'd0);
    idle(1);
    check_val("grp_we",    {31'b0, mem_a.mem_we}, 32'd1);
    check_val("grp_addr",  {20'b0, mem_a.mem_addr}, 32'h801);
    check_val("grp_data",  mem_a.mem_wdata, 32'd106);
    check_val("grp_ptr",   {22'b0, ecg_ptr}, 32'd1);
    idle(1);
    check_val("idle_we_low",    {31'b0, mem_a.mem_we}, 32'd0);
    check_val("idle_addr_hold", {20'b0, mem_a.mem_addr}, 32'h801);

    // Simultaneous completion: ECG first, EMG next, then the following tie goes to EMG
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'($urandom), 1'b1, 12'($urandom), 1'b0);
    idle(1);
    check_val("tie_lat", {31'b0, mem_a.mem_we}, 32'd0);
    idle(1);
    check_val("tie1_ecg_addr", {20'b0, mem_a.mem_addr}, 32'h801);
    idle(1);
    check_val("tie1_emg_we",   {31'b0, mem_a.mem_we}, 32'd1);
    check_val("tie1_emg_addr", {20'b0, mem_a.mem_addr}, 32'h559);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'($urandom), 1'b1, 12'($urandom), 1'b0);
    idle(2);
    check_val("tie2_emg_addr", {20'b0, mem_a.mem_addr}, 32'h55A);
    idle(1);
    check_val("tie2_ecg_addr", {20'b0, mem_a.mem_addr}, 32'h802);
    idle(2);

    // Full EMG trace of 0xFFF, then wrap
    do_reset();
    for (int g = 0; g < DEPTH; g++)
      for (int i = 0; i < 4; i++) cyc(1'b0, 12'd0, 1'b1, 12'hFFF, 1'b0);
    idle(3);
    check_val("wrap_last_addr", {20'b0, last_addr}, 32'h7D8);
    check_val("wrap_ptr_zero",  {22'b0, emg_ptr}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 12'd0, 1'b1, 12'hFFF, 1'b0);
    idle(3);
    check_val("wrap_next_addr", {20'b0, last_addr}, 32'h559);
    check_val("wrap_next_ptr",  {22'b0, emg_ptr}, 32'd1);

    // Freeze mid-group; already-pending entries still drain under freeze
    do_reset();
    cyc(1'b1, 12'd10, 1'b0, 12'd0, 1'b0);
    cyc(1'b1, 12'd20, 1'b0, 12'd0, 1'b0);
    w0 = writes_a;
    repeat (10) cyc(1'b1, 12'($urandom), 1'b1, 12'($urandom), 1'b1);
    idle(2);
    check_val("freeze_no_write", writes_a, w0);
    cyc(1'b1, 12'd30, 1'b0, 12'd0, 1'b0);
    cyc(1'b1, 12'd40, 1'b0, 12'd0, 1'b0);
    idle(3);
    check_val("freeze_resume_cnt",  writes_a, w0 + 1);
    check_val("freeze_resume_data", mem_a.mem_wdata, 32'd25);
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'd8, 1'b0, 12'd0, 1'b0);
    repeat (3) cyc(1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
    check_val("drain_under_freeze", writes_a, w0 + 2);
    idle(1);

    // Reset with partial ECG group and pending EMG entry
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'd50, 1'b1, 12'd60, 1'b0);
    cyc(1'b0, 12'd0, 1'b1, 12'd70, 1'b0);
    idle(1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'(i + 1), 1'b0, 12'd0, 1'b0);
    idle(3);
    check_val("mid_rst_addr",    {20'b0, last_addr}, 32'h801);
    check_val("mid_rst_data",    mem_a.mem_wdata, 32'd2);
    check_val("mid_rst_emg_ptr", {22'b0, emg_ptr}, 32'd0);

    // Overrun on the direct-load build: ECG keeps the arbiter busy
    do_reset();
    b_ecg_valid = 1'b1; b_ecg_sample = 12'd1; b_emg_valid = 1'b1; b_emg_sample = 12'h111;
    idle(1);
    b_ecg_sample = 12'd2; b_emg_sample = 12'h222;
    idle(1);
    b_ecg_valid = 1'b0; b_emg_valid = 1'b0;
    check_val("ovr_ecg_first_addr", {20'b0, mem_b.mem_addr}, 32'h801);
    check_val("ovr_ecg_first_data", mem_b.mem_wdata, 32'd1);
    check_val("ovr_emg_flag",       {31'b0, b_emg_ovr}, 32'd1);
    idle(1);
    check_val("ovr_emg_addr", {20'b0, mem_b.mem_addr}, 32'h559);
    check_val("ovr_emg_data", mem_b.mem_wdata, 32'h222);
    idle(1);
    check_val("ovr_ecg_second_data", mem_b.mem_wdata, 32'd2);
    idle(1);
    check_val("ovr_emg_single_write", {22'b0, b_emg_ptr}, 32'd1);
    check_val("ovr_ecg_no_flag",      {31'b0, b_ecg_ovr}, 32'd0);
    b_clear_ovr = 1'b1;
    idle(1);
    b_clear_ovr = 1'b0;
    check_val("ovr_cleared", {31'b0, b_emg_ovr}, 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 3) == 0, 12'($urandom), ($urandom % 3) == 0, 12'($urandom),
          ($urandom % 10) == 0);
    idle(4);
    check_val("rand_ecg_drained", exp_ecg.size(), 0);
    check_val("rand_emg_drained", exp_emg.size(), 0);
    check_val("rand_ecg_ptr", {22'b0, ecg_ptr}, m_idx[0]);
    check_val("rand_emg_ptr", {22'b0, emg_ptr}, m_idx[1]);
    check_val("rand_no_ovr",  {30'b0, ecg_ovr, emg_ovr}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
